// File: rtl/rf_wport_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wport_arbiter
//
// Owns the single GPR write port and shares it between the pipeline WB stage
// and the multi-cycle MDU. WB has priority. MDU results wait in a small FIFO
// and drain in write slots that WB leaves idle. A WB instruction that is held
// by a stall re-presents the same PC, so a repeated PC is not committed twice.
// If WB keeps the port busy for STARVE_LIMIT consecutive cycles while MDU
// results are waiting, one cycle is forced for the MDU by holding WB.
//
// Configuration macro: WB_TRACE_EN
//   defined   : debug_wb_* report every write issued on the port
//   undefined : debug_wb_* are tied to 0 and the trace registers are removed
//
// Parameters
//   FIFO_DEPTH    MDU result FIFO entries (power of 2, >= 2)
//   STARVE_LIMIT  blocked cycles with a waiting MDU result before a forced slot
//
// Ports
//   clk, reset          clock; synchronous active-low reset
//   wb_valid/pc/we/waddr/wdata   WB stage instruction and write request
//   wb_hold             WB stage must keep its contents this cycle
//   mdu_valid/ready     MDU result handshake
//   mdu_pc/waddr/wdata  MDU result fields
//   rf_we/waddr/wdata   register-file write port (registered, 1-cycle latency)
//   debug_wb_*          trace of the write issued on the port
//   debug_state         arbiter FSM state (0 = NORMAL, 1 = FORCE)
//
// Handshake: an MDU result is transferred on every rising clock edge where
// mdu_valid and mdu_ready are both high. mdu_ready depends only on FIFO
// occupancy (never on mdu_valid), and the MDU keeps mdu_valid and its fields
// stable until the transfer happens.
// ---------------------------------------------------------------------------
module rf_wport_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    output logic        wb_hold,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [31:0] mdu_pc,
    input  logic [4:0]  mdu_waddr,
    input  logic [31:0] mdu_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic        debug_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    // Registered state
    state_t          state_q;
    logic [CW-1:0]   starve_cnt_q;
    logic [31:0]     last_pc_q;
    logic            last_pc_vld_q;
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;
    logic            rf_we_q;
    logic [4:0]      rf_waddr_q;
    logic [31:0]     rf_wdata_q;

    // FIFO storage (no reset needed: occupancy is tracked by the pointers)
    logic [4:0]      fifo_waddr_q [FIFO_DEPTH];
    logic [31:0]     fifo_wdata_q [FIFO_DEPTH];

    // Next-state / decision signals
    state_t          state_d;
    logic [CW-1:0]   starve_cnt_d;
    logic            fifo_empty;
    logic            fifo_full;
    logic            wb_commit;
    logic            wb_slot;
    logic            grant_wb;
    logic            grant_mdu;
    logic            starve_inc;
    logic            push;
    logic            pop;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

    assign mdu_ready  = !fifo_full;
    assign wb_hold    = (state_q == ST_FORCE);

    always_comb begin
        wb_commit    = wb_valid && !wb_hold &&
                       (!last_pc_vld_q || (wb_pc != last_pc_q));
        wb_slot      = wb_commit && wb_we && (wb_waddr != 5'd0);
        grant_wb     = (state_q == ST_NORMAL) && wb_slot;
        // FIFO is never empty in FORCE: the head is not popped while blocked.
        grant_mdu    = !fifo_empty && ((state_q == ST_FORCE) || !wb_slot);
        starve_inc   = grant_wb && !fifo_empty;
        starve_cnt_d = starve_inc ? (starve_cnt_q + CW'(1)) : '0;
        state_d      = (starve_inc && (starve_cnt_q == CW'(STARVE_LIMIT - 1)))
                       ? ST_FORCE : ST_NORMAL;
        // Results for $0 are accepted but never stored.
        push         = mdu_valid && mdu_ready && (mdu_waddr != 5'd0);
        pop          = grant_mdu;
    end

    // Arbiter FSM, duplicate-PC tracker, FIFO pointers and write-port outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_NORMAL;
            starve_cnt_q  <= '0;
            last_pc_q     <= '0;
            last_pc_vld_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            if (wb_commit) begin
                last_pc_q     <= wb_pc;
                last_pc_vld_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
            if (grant_wb) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= wb_waddr;
                rf_wdata_q <= wb_wdata;
            end else if (grant_mdu) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= fifo_waddr_q[rd_idx];
                rf_wdata_q <= fifo_wdata_q[rd_idx];
            end else begin
                rf_we_q    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_waddr_q[wr_idx] <= mdu_waddr;
            fifo_wdata_q[wr_idx] <= mdu_wdata;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign debug_state = state_q;

`ifdef WB_TRACE_EN
    logic [31:0] fifo_pc_q [FIFO_DEPTH];
    logic [31:0] dbg_pc_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_idx] <= mdu_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dbg_pc_q <= '0;
        end else if (grant_wb) begin
            dbg_pc_q <= wb_pc;
        end else if (grant_mdu) begin
            dbg_pc_q <= fifo_pc_q[rd_idx];
        end
    end

    assign debug_wb_pc       = dbg_pc_q;
    assign debug_wb_rf_wen   = {4{rf_we_q}};
    assign debug_wb_rf_wnum  = rf_waddr_q;
    assign debug_wb_rf_wdata = rf_wdata_q;
`else
    // The MDU PC only feeds the trace, which is absent in this build.
    logic unused_mdu_pc;
    assign unused_mdu_pc = ^mdu_pc;

    assign debug_wb_pc       = '0;
    assign debug_wb_rf_wen   = '0;
    assign debug_wb_rf_wnum  = '0;
    assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
module tb_rf_wport_arbiter;

    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT ----------------
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_hold;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [31:0] mdu_pc;
    logic [4:0]  mdu_waddr;
    logic [31:0] mdu_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        debug_state;

    rf_wport_arbiter #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .wb_valid          (wb_valid),
        .wb_pc             (wb_pc),
        .wb_we             (wb_we),
        .wb_waddr          (wb_waddr),
        .wb_wdata          (wb_wdata),
        .wb_hold           (wb_hold),
        .mdu_valid         (mdu_valid),
        .mdu_ready         (mdu_ready),
        .mdu_pc            (mdu_pc),
        .mdu_waddr         (mdu_waddr),
        .mdu_wdata         (mdu_wdata),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .debug_state       (debug_state)
    );

    // ---------------- scoreboard ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;
    int we_cnt    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: queued MDU results {pc, waddr, wdata}, last committed
    // PC, run length of WB-won cycles while results wait, pending forced slot.
    logic [68:0] exp_q[$];
    logic [31:0] m_last_pc;
    bit          m_last_vld;
    int          m_blocked;
    bit          m_force;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [31:0] e_pc;

    task automatic model_edge();
        logic [68:0] h;
        bit commit, wb_write, had, push;
        if (!reset) begin
            exp_q.delete();
            m_last_pc  = '0;
            m_last_vld = 0;
            m_blocked  = 0;
            m_force    = 0;
            e_we = 1'b0; e_waddr = '0; e_wdata = '0; e_pc = '0;
        end else begin
            had      = (exp_q.size() != 0);
            commit   = wb_valid && !m_force && (!m_last_vld || wb_pc != m_last_pc);
            wb_write = commit && wb_we && (wb_waddr != 5'd0);
            push     = mdu_valid && (exp_q.size() < FIFO_DEPTH) && (mdu_waddr != 5'd0);
            if (m_force || (!wb_write && had)) begin
                h = exp_q.pop_front();
                e_we = 1'b1; e_pc = h[68:37]; e_waddr = h[36:32]; e_wdata = h[31:0];
                m_blocked = 0;
                m_force   = 0;
            end else if (wb_write) begin
                e_we = 1'b1; e_pc = wb_pc; e_waddr = wb_waddr; e_wdata = wb_wdata;
                if (had) begin
                    m_blocked++;
                    if (m_blocked == STARVE_LIMIT) m_force = 1;
                end else begin
                    m_blocked = 0;
                end
            end else begin
                e_we = 1'b0;
                m_blocked = 0;
            end
            if (commit) begin
                m_last_pc  = wb_pc;
                m_last_vld = 1;
            end
            if (push) exp_q.push_back({mdu_pc, mdu_waddr, mdu_wdata});
        end
    endtask

    // One clock: inputs are set by the caller just after a falling edge.
    task automatic step();
        #1;
        chk("wb_hold", 32'(wb_hold), 32'(m_force));
        chk("mdu_ready", 32'(mdu_ready), 32'(exp_q.size() < FIFO_DEPTH));
        model_edge();
        @(posedge clk);
        @(negedge clk);
        if (rf_we === 1'b1) we_cnt++;
        chk("rf_we", 32'(rf_we), 32'(e_we));
        chk("rf_waddr", 32'(rf_waddr), 32'(e_waddr));
        chk("rf_wdata", rf_wdata, e_wdata);
`ifdef WB_TRACE_EN
        chk("dbg_pc", debug_wb_pc, e_pc);
        chk("dbg_wen", 32'(debug_wb_rf_wen), 32'({4{e_we}}));
        chk("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(e_waddr));
        chk("dbg_wdata", debug_wb_rf_wdata, e_wdata);
`else
        chk("dbg_pc", debug_wb_pc, 32'd0);
        chk("dbg_wen", 32'(debug_wb_rf_wen), 32'd0);
        chk("dbg_wnum", 32'(debug_wb_rf_wnum), 32'd0);
        chk("dbg_wdata", debug_wb_rf_wdata, 32'd0);
`endif
    endtask

    task automatic set_idle();
        wb_valid = 1'b0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
        mdu_valid = 1'b0; mdu_waddr = '0; mdu_wdata = '0; mdu_pc = '0;
    endtask

    task automatic set_wb(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1'b1; wb_we = 1'b1; wb_pc = pc; wb_waddr = a; wb_wdata = d;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int base, offer, wi, hold_k, held_cnt, cnt;
        bit prev_hold, hold_now, acc, first3;
        logic [31:0] held_data;

        // Reset for two cycles with every input active.
        reset = 1'b0;
        set_wb(32'h0, 5'd5, 32'h1234);
        mdu_valid = 1'b1; mdu_pc = 32'h80; mdu_waddr = 5'd9; mdu_wdata = 32'h99;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        step();
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_wb_hold", 32'(wb_hold), 32'd0);
        chk("rst_mdu_ready", 32'(mdu_ready), 32'd1);

        // First WB after reset with pc=0 commits.
        reset = 1'b1;
        set_idle();
        set_wb(32'h0, 5'd3, 32'h33);
        step();
        chk("first_wb_we", 32'(rf_we), 32'd1);
        chk("first_wb_addr", 32'(rf_waddr), 32'd3);

        // Same PC presented for three cycles: exactly one write.
        set_wb(32'h1000, 5'd5, 32'hA);
        base = we_cnt;
        step();
`ifdef WB_TRACE_EN
        chk("dup_wen_first", 32'(debug_wb_rf_wen), 32'hF);
`endif
        step();
`ifdef WB_TRACE_EN
        chk("dup_wen_second", 32'(debug_wb_rf_wen), 32'h0);
`endif
        step();
        chk("dup_pulses", 32'(we_cnt - base), 32'd1);

        // MDU result drains two cycles after the push while WB is idle.
        set_idle();
        mdu_valid = 1'b1; mdu_pc = 32'h2000; mdu_waddr = 5'd7; mdu_wdata = 32'h55;
        step();
        mdu_valid = 1'b0;
        chk("drain_not_yet", 32'(rf_we), 32'd0);
        step();
        chk("drain_we", 32'(rf_we), 32'd1);
        chk("drain_addr", 32'(rf_waddr), 32'd7);
        chk("drain_data", rf_wdata, 32'h55);

        // Full FIFO: three MDU offers while WB writes a new PC each cycle.
        offer = 0; wi = 0; prev_hold = 0; first3 = 0;
        for (int c = 0; c < 20 && offer < 3; c++) begin
            if (!prev_hold) begin
                wi++;
                set_wb(32'h3000 + 32'(wi) * 4, 5'(1 + wi % 8), 32'hB000 + 32'(wi));
            end
            mdu_valid = 1'b1; mdu_pc = 32'h4000 + 32'(offer) * 4;
            mdu_waddr = 5'(10 + offer); mdu_wdata = 32'hC0 + 32'(offer);
            if (offer == 2 && !first3) begin
                first3 = 1;
                chk("full_ready_3rd", 32'(mdu_ready), 32'd0);
            end
            hold_now = wb_hold;
            acc = mdu_ready;
            step();
            prev_hold = hold_now;
            if (acc) offer++;
        end
        chk("full_accept_timeout", 32'(offer), 32'd3);
        set_idle();
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (rf_we === 1'b1 && rf_waddr == 5'd12 && rf_wdata == 32'hC2) cnt++;
        end
        chk("full_third_written", 32'(cnt), 32'd1);

        // Starvation: one waiting result, WB writes a new PC every cycle.
        wi = 0; prev_hold = 0; hold_k = -1; held_cnt = 0; held_data = '0;
        for (int k = 0; k < 10; k++) begin
            if (!prev_hold) begin
                wi++;
                set_wb(32'h5000 + 32'(wi) * 4, 5'(1 + wi % 16), 32'hD000 + 32'(wi));
            end
            mdu_valid = (k == 0); mdu_pc = 32'h9000; mdu_waddr = 5'd20; mdu_wdata = 32'hE1;
            hold_now = wb_hold;
            if (hold_now && hold_k < 0) begin
                hold_k = k;
                held_data = wb_wdata;
            end
            step();
            prev_hold = hold_now;
            if (k == hold_k) begin
                chk("starve_mdu_we", 32'(rf_we), 32'd1);
                chk("starve_mdu_data", rf_wdata, 32'hE1);
            end
            if (hold_k >= 0 && rf_we === 1'b1 && rf_wdata == held_data) held_cnt++;
        end
        chk("starve_hold_cycle", 32'(hold_k), 32'(STARVE_LIMIT + 1));
        chk("starve_held_commit_once", 32'(held_cnt), 32'd1);

        // Writes to $0 from WB and from the MDU are dropped.
        set_idle();
        set_wb(32'h6000, 5'd0, 32'hDEAD);
        step();
        chk("wb_r0_we", 32'(rf_we), 32'd0);
        set_idle();
        mdu_valid = 1'b1; mdu_pc = 32'h6100; mdu_waddr = 5'd0; mdu_wdata = 32'hBEEF;
        step();
        set_idle();
        step();
        chk("mdu_r0_we", 32'(rf_we), 32'd0);

        // Reset with two queued results flushes them.
        for (int k = 0; k < 2; k++) begin
            set_wb(32'h7000 + 32'(k) * 4, 5'd2, 32'h700 + 32'(k));
            mdu_valid = 1'b1; mdu_pc = 32'h8000 + 32'(k) * 4;
            mdu_waddr = 5'(16 + k); mdu_wdata = 32'h800 + 32'(k);
            step();
        end
        set_idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        base = we_cnt;
        for (int k = 0; k < 5; k++) step();
        chk("flush_no_mdu_write", 32'(we_cnt - base), 32'd0);
        set_wb(32'h7004, 5'd4, 32'h77);
        step();
        chk("post_reset_same_pc_commits", 32'(rf_we), 32'd1);

        // Randomized traffic against the reference model.
        set_idle();
        wb_pc = 32'h10000; prev_hold = 0;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) != 0);
            if (!prev_hold) begin
                wb_valid = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 2) != 0) wb_pc = wb_pc + 4;
                wb_we    = ($urandom_range(0, 4) != 0);
                wb_waddr = 5'($urandom_range(0, 31));
                wb_wdata = $urandom;
            end
            if (!mdu_valid && $urandom_range(0, 9) < 4) begin
                mdu_valid = 1'b1;
                mdu_pc    = $urandom;
                mdu_waddr = 5'($urandom_range(0, 15));
                mdu_wdata = $urandom;
            end
            hold_now = wb_hold;
            acc = mdu_valid && mdu_ready;
            step();
            prev_hold = hold_now && reset;
            if (acc) mdu_valid = 1'b0;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
